ibex_md_iter_ctrl: RTL and testbench

- Iterative multiply/divide sequencer for RV32M, selected by md_op_e (MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM).
- Sits beside the ALU in the EX stage. Accepts one operation at a time over a valid/ready handshake and runs a radix-2 shift-add / restoring-divide loop on operand magnitudes.
- Returns one 32-bit result over a second valid/ready handshake; the ID-stage controller can kill an operation in flight.

---
 rtl/ibex_md_iter_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_ibex_md_iter_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_md_iter_ctrl.sv
// Iterative RV32M multiply/divide sequencer: one radix-2 step per cycle on operand magnitudes,
// with sign fix-up at the end and valid/ready handshakes on request and result.
module ibex_md_iter_ctrl #(
    parameter bit DivZeroShortcut = 1'b1,
    parameter bit MulEarlyOut     = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] result_o
);

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ABS  = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e      state_q, state_d;
    md_op_e      op_q, op_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [63:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] rem_q, rem_d;
    logic        sign_q, sign_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] result_q, result_d;
    logic        res_valid_q, res_valid_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;

    logic        sa, sb, is_div, b_zero, div_ge, calc_last;
    logic [31:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [32:0] div_shift;
    logic [63:0] prod_fix;

    assign sa     = opa_q[31] & mode_q[0];
    assign sb     = opb_q[31] & mode_q[1];
    assign abs_a  = sa ? -opa_q : opa_q;
    assign abs_b  = sb ? -opb_q : opb_q;
    assign is_div = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
    assign b_zero = (opb_q == 32'd0);

    // Dividend bits shift out of opa_q into the partial remainder; opa_q collects the quotient.
    assign div_shift = {rem_q, opa_q[31]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign calc_last = (count_q == 5'd0) ||
                       (MulEarlyOut && !is_div && (opb_q[31:1] == 31'd0));

    assign prod_fix = sign_q ? -acc_q : acc_q;
    assign quo_fix  = sign_q ? -opa_q : opa_q;
    assign rem_fix  = sign_q ? -rem_q : rem_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mode_d      = mode_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        sign_d      = sign_q;
        count_d     = count_q;
        result_d    = result_q;
        res_valid_d = res_valid_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !kill_i) begin
                    op_d        = md_op_e'(operator_i);
                    mode_d      = signed_mode_i;
                    opa_d       = op_a_i;
                    opb_d       = op_b_i;
                    state_d     = S_ABS;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            S_ABS: begin
                opa_d   = abs_a;
                opb_d   = abs_b;
                mcand_d = {32'd0, abs_a};
                acc_d   = 64'd0;
                rem_d   = 32'd0;
                count_d = 5'd31;
                // A zero divisor must yield an all-ones quotient, so its sign is never applied.
                if (op_q == MD_OP_REM) begin
                    sign_d = sa;
                end else if (is_div) begin
                    sign_d = (sa ^ sb) & ~b_zero;
                end else begin
                    sign_d = sa ^ sb;
                end
                if (is_div && b_zero && DivZeroShortcut) begin
                    result_d    = (op_q == MD_OP_DIV) ? 32'hFFFF_FFFF : opa_q;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (is_div) begin
                    opa_d = {opa_q[30:0], div_ge};
                    rem_d = div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
                end else begin
                    if (opb_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d = {mcand_q[62:0], 1'b0};
                    opb_d   = {1'b0, opb_q[31:1]};
                end
                count_d = count_q - 5'd1;
                if (calc_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                case (op_q)
                    MD_OP_MULL: result_d = prod_fix[31:0];
                    MD_OP_MULH: result_d = prod_fix[63:32];
                    MD_OP_DIV:  result_d = quo_fix;
                    default:    result_d = rem_fix;
                endcase
                res_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                res_valid_d = 1'b0;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase

        if (kill_i) begin
            state_d     = S_IDLE;
            res_valid_d = 1'b0;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
            result_d    = 32'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= MD_OP_MULL;
            mode_q      <= 2'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            mcand_q     <= 64'd0;
            acc_q       <= 64'd0;
            rem_q       <= 32'd0;
            sign_q      <= 1'b0;
            count_q     <= 5'd0;
            result_q    <= 32'd0;
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mode_q      <= mode_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            sign_q      <= sign_d;
            count_q     <= count_d;
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign result_o    = result_q;

endmodule

// File: tb/tb_ibex_md_iter_ctrl.sv
// Bench for ibex_md_iter_ctrl: directed vector table, randomized ops against a longint model,
// and hand-written backpressure / kill / reset sequences. Instance 1 uses the full-loop divide-by-zero and mul early-out.
module tb_ibex_md_iter_ctrl;

    localparam logic [1:0] OP_MULL = 2'd0;
    localparam logic [1:0] OP_MULH = 2'd1;
    localparam logic [1:0] OP_DIV  = 2'd2;
    localparam logic [1:0] OP_REM  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, kill, res_ready, sel;
    logic [1:0]  operator, mode;
    logic [31:0] op_a, op_b;

    logic        req_ready0, busy0, res_valid0;
    logic        req_ready1, busy1, res_valid1;
    logic [31:0] result0, result1;
    logic        req_ready_s, busy_s, res_valid_s;
    logic [31:0] result_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ibex_md_iter_ctrl dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid && !sel), .req_ready_o(req_ready0),
        .operator_i(operator), .signed_mode_i(mode), .op_a_i(op_a), .op_b_i(op_b),
        .kill_i(kill && !sel), .busy_o(busy0),
        .res_valid_o(res_valid0), .res_ready_i(res_ready && !sel), .result_o(result0)
    );

    ibex_md_iter_ctrl #(.DivZeroShortcut(1'b0), .MulEarlyOut(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid && sel), .req_ready_o(req_ready1),
        .operator_i(operator), .signed_mode_i(mode), .op_a_i(op_a), .op_b_i(op_b),
        .kill_i(kill && sel), .busy_o(busy1),
        .res_valid_o(res_valid1), .res_ready_i(res_ready && sel), .result_o(result1)
    );

    assign req_ready_s = sel ? req_ready1 : req_ready0;
    assign busy_s      = sel ? busy1      : busy0;
    assign res_valid_s = sel ? res_valid1 : res_valid0;
    assign result_s    = sel ? result1    : result0;

    typedef struct {
        logic        sel;
        logic [1:0]  op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] model(logic [1:0] op, logic [1:0] md, logic [31:0] a, logic [31:0] b);
        longint av, bv, p;
        av = md[0] ? longint'($signed(a)) : longint'({32'd0, a});
        bv = md[1] ? longint'($signed(b)) : longint'({32'd0, b});
        case (op)
            OP_MULL: begin p = av * bv; return p[31:0]; end
            OP_MULH: begin p = av * bv; return p[63:32]; end
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = av / bv;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = av % bv;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 300));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Runs one operation on the selected instance; lat counts clock edges from the accept edge to res_valid_o.
    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] md, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res, output int lat,
                                 output bit ready_ok, output bit timed_out);
        @(negedge clk);
        req_valid = 1'b1;
        operator  = op;
        mode      = md;
        op_a      = a;
        op_b      = b;
        @(negedge clk);
        req_valid = 1'b0;
        operator  = 2'($urandom);
        mode      = 2'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        lat       = 0;
        res       = 32'd0;
        ready_ok  = 1'b1;
        timed_out = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (res_valid_s) begin
                lat       = n;
                timed_out = 1'b0;
                break;
            end
            if (req_ready_s) ready_ok = 1'b0;
            res_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (!timed_out) begin
            res       = result_s;
            res_ready = 1'b1;
            @(negedge clk);
            checkOutput("release_valid", 32'(res_valid_s), 32'd0);
            checkOutput("release_ready", 32'(req_ready_s), 32'd1);
        end
        res_ready = 1'b0;
    endtask

    task automatic runChecked(input string name, input logic s, input logic [1:0] op, input logic [1:0] md,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int          lat;
        bit          ready_ok, timed_out;
        sel = s;
        applyStimulus(op, md, a, b, res, lat, ready_ok, timed_out);
        checkOutput({name, "_timeout"}, 32'(timed_out), 32'd0);
        checkOutput({name, "_result"}, res, exp);
        checkOutput({name, "_ready_low"}, 32'(ready_ok), 32'd1);
        if (exp_lat != 0) checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic waitValid(input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = res_valid_s;
        end
        checkOutput({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0; res_ready = 1'b0; sel = 1'b0;
        operator = OP_MULL; mode = 2'd0; op_a = 32'd0; op_b = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready0", 32'(req_ready0), 32'd1);
        checkOutput("reset_busy0", 32'(busy0), 32'd0);
        checkOutput("reset_valid0", 32'(res_valid0), 32'd0);
        checkOutput("reset_result0", result0, 32'd0);
        checkOutput("reset_ready1", 32'(req_ready1), 32'd1);
        checkOutput("reset_valid1", 32'(res_valid1), 32'd0);
        rst_n = 1'b1;

        vecs.push_back('{1'b0, OP_MULL, 2'b00, 32'd7,          32'd6,          32'd42,         34});
        vecs.push_back('{1'b0, OP_MULH, 2'b11, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  34});
        vecs.push_back('{1'b0, OP_MULH, 2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34});
        vecs.push_back('{1'b0, OP_MULH, 2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34});
        vecs.push_back('{1'b0, OP_MULL, 2'b11, 32'hFFFF_FFF9,  32'hFFFF_FFFD,  32'd21,         34});
        vecs.push_back('{1'b0, OP_DIV,  2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34});
        vecs.push_back('{1'b0, OP_REM,  2'b11, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34});
        vecs.push_back('{1'b0, OP_DIV,  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34});
        vecs.push_back('{1'b0, OP_REM,  2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34});
        vecs.push_back('{1'b0, OP_DIV,  2'b00, 32'd100,        32'd7,          32'd14,         34});
        vecs.push_back('{1'b0, OP_REM,  2'b00, 32'd100,        32'd7,          32'd2,          34});
        vecs.push_back('{1'b0, OP_DIV,  2'b11, 32'd123,        32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{1'b0, OP_REM,  2'b11, 32'd123,        32'd0,          32'd123,        1});
        vecs.push_back('{1'b0, OP_DIV,  2'b11, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{1'b0, OP_REM,  2'b11, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1});
        vecs.push_back('{1'b1, OP_DIV,  2'b00, 32'd123,        32'd0,          32'hFFFF_FFFF,  34});
        vecs.push_back('{1'b1, OP_REM,  2'b00, 32'd123,        32'd0,          32'd123,        34});
        vecs.push_back('{1'b1, OP_DIV,  2'b11, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  34});
        vecs.push_back('{1'b1, OP_REM,  2'b11, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  34});
        vecs.push_back('{1'b1, OP_MULL, 2'b00, 32'd3,          32'd5,          32'd15,         0});
        vecs.push_back('{1'b1, OP_MULH, 2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  0});
        vecs.push_back('{1'b1, OP_MULL, 2'b11, 32'h8000_0000,  32'd1,          32'h8000_0000,  0});
        vecs.push_back('{1'b1, OP_MULH, 2'b11, 32'h8000_0000,  32'd1,          32'hFFFF_FFFF,  0});

        foreach (vecs[i]) begin
            runChecked($sformatf("vec%0d", i), vecs[i].sel, vecs[i].op, vecs[i].mode,
                       vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  rop, rmd;
            logic [31:0] ra, rb;
            int          elat;
            rop  = 2'($urandom);
            rmd  = 2'($urandom);
            ra   = pick_operand();
            rb   = pick_operand();
            elat = 34;
            if (i % 2 == 1) begin
                if (rop == OP_MULL || rop == OP_MULH) elat = 0;
            end else if ((rop == OP_DIV || rop == OP_REM) && rb == 32'd0) begin
                elat = 1;
            end
            runChecked($sformatf("rand%0d", i), 1'(i % 2), rop, rmd, ra, rb, model(rop, rmd, ra, rb), elat);
        end

        // Backpressure: result must hold while DONE and new requests are ignored.
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; operator = OP_MULL; mode = 2'b00; op_a = 32'd7; op_b = 32'd6;
        @(negedge clk);
        req_valid = 1'b0;
        waitValid("bp");
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1; operator = OP_MULH; op_a = $urandom; op_b = $urandom;
            @(negedge clk);
            checkOutput("bp_result", result_s, 32'd42);
            checkOutput("bp_valid", 32'(res_valid_s), 32'd1);
            checkOutput("bp_ready", 32'(req_ready_s), 32'd0);
        end
        req_valid = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("bp_release_valid", 32'(res_valid_s), 32'd0);
        checkOutput("bp_release_ready", 32'(req_ready_s), 32'd1);
        @(negedge clk);
        checkOutput("bp_no_accept", 32'(busy_s), 32'd0);

        // Kill during CALC at count 15.
        @(negedge clk);
        req_valid = 1'b1; operator = OP_DIV; mode = 2'b11; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (17) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill_busy", 32'(busy_s), 32'd0);
        checkOutput("kill_ready", 32'(req_ready_s), 32'd1);
        checkOutput("kill_valid", 32'(res_valid_s), 32'd0);
        begin
            bit seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (res_valid_s) seen = 1'b1;
            end
            checkOutput("kill_no_result", 32'(seen), 32'd0);
        end
        runChecked("after_kill", 1'b0, OP_MULL, 2'b00, 32'd3, 32'd5, 32'd15, 34);

        // Kill in IDLE blocks acceptance.
        @(negedge clk);
        req_valid = 1'b1; kill = 1'b1; operator = OP_MULL; op_a = 32'd2; op_b = 32'd2;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        checkOutput("idle_kill_busy", 32'(busy_s), 32'd0);

        // Kill while DONE discards the result.
        @(negedge clk);
        req_valid = 1'b1; operator = OP_MULL; mode = 2'b00; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        req_valid = 1'b0;
        waitValid("done_kill");
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("done_kill_valid", 32'(res_valid_s), 32'd0);
        checkOutput("done_kill_ready", 32'(req_ready_s), 32'd1);

        // Asynchronous reset mid-CALC with a stale nonzero result register.
        runChecked("pre_reset", 1'b0, OP_MULL, 2'b00, 32'd7, 32'd6, 32'd42, 34);
        @(negedge clk);
        req_valid = 1'b1; operator = OP_MULL; mode = 2'b00; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(req_ready_s), 32'd1);
        checkOutput("rst_busy", 32'(busy_s), 32'd0);
        checkOutput("rst_valid", 32'(res_valid_s), 32'd0);
        checkOutput("rst_result", result_s, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runChecked("after_reset", 1'b0, OP_MULL, 2'b00, 32'd3, 32'd5, 32'd15, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
